ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Replaces the single-cycle instruction ROM path with a request/acknowledge instruction-memory interface of variable latency.
- Prefetches sequential words into a small FIFO and presents {instruction, pc+4} to IF/ID.
- Honours the hazard unit's freeze and the branch/jump redirect resolved in ID.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
redirect  in  1  branch/jump taken in ID this cycle (pcSrc != 0)
redirect_pc  in  32  target address (pc_branch or pc_jump)
freeze  in  1  IF/ID not accepting; no pop
imem_req  out  1  instruction read request
imem_addr  out  32  word address, bits[1:0] = 0
imem_ack  in  1  read data valid this cycle, completes request
imem_rdata  in  32  instruction word
inst_valid  out  1  head entry valid for IF/ID
inst  out  32  head instruction
inst_next_pc  out  32  head entry's pc + 4

Behaviour:
- Reset (rst = 0, async): FIFO empty, count = 0, state IDLE, fetch_pc = RESET_PC, imem_req = 0, imem_addr = RESET_PC, inst_valid = 0, inst = 0, inst_next_pc = 0.
- pop = inst_valid & ~freeze.
- inst_valid = ~empty & ~redirect. A redirect cycle never delivers; the in-flight wrong-path word is squashed by IF/ID Flush.
- imem_req and imem_addr are registered. They stay stable from assertion until the cycle imem_ack = 1 (exactly one outstanding request). imem_ack while imem_req = 0 is ignored.
- space = DEPTH − count − (outstanding ? 1 : 0), evaluated after this cycle's pop/push.
- FSM states:
  - IDLE: go to FETCH on the next edge after reset release.
  - FETCH: imem_req = 1. On ack: push rdata with tag fetch_pc + 4, fetch_pc += 4. If space > 0, stay in FETCH with the new address on the next cycle (zero-wait memory yields 1 instruction/cycle); else go to FULL (req = 0).
  - FULL: req = 0. Go to FETCH when space > 0.
  - DISCARD: req held at the old address until ack. Ack data is dropped, then go to FETCH at pending_pc.
- Redirect rules (all flush the FIFO, count = 0, in the same edge):
  - In FETCH without ack: go to DISCARD, pending_pc = redirect_pc.
  - In FETCH with ack the same cycle: drop the data, go to FETCH with imem_addr = redirect_pc on the next cycle.
  - In FULL or IDLE: go to FETCH at redirect_pc.
  - In DISCARD: update pending_pc to the latest redirect_pc.
- Push and pop in the same cycle: count unchanged. Full + pop + ack is legal.
- Pointers wrap modulo DEPTH. fetch_pc wraps modulo 2^32.
- redirect_pc[1:0] is forced to 0.
- Latency, non-bypass build: ack edge → inst_valid on the next cycle.

Optional Feature:
IFQ_BYPASS_EN
- Defined: when the FIFO is empty, imem_ack = 1, redirect = 0 and the state is FETCH, the word is driven combinationally onto inst/inst_next_pc with inst_valid = 1 in the same cycle. If also ~freeze, it is consumed without being written to the FIFO; otherwise it is pushed normally.
- Undefined: inst_valid is a pure function of registered FIFO state; ack-to-valid latency is 1 cycle.

Decomposition:
- Package ifq_pkg:
  - state typedef {IDLE, FETCH, FULL, DISCARD}
  - INSN_W = 32, PC_INC = 4
  - entry typedef {insn[31:0], next_pc[31:0]}
- Sub-module ifq_fifo: DEPTH-entry synchronous FIFO with push, pop, flush, count, async active-low reset. The top holds the FSM, fetch_pc, pending_pc and the handshake.

Test Plan:
- Reset, zero-wait memory (ack whenever req), freeze = 0: imem_addr = 0, 4, 8, … on consecutive cycles; inst_next_pc = 4, 8, 12 from the cycle after the first ack (same cycle with IFQ_BYPASS_EN).
- freeze = 1 for 10 cycles, zero-wait memory: exactly 4 pushes, then imem_req = 0 (FULL). Release freeze: 4 entries pop in order, then req reasserts.
- Memory latency 3 cycles; redirect to 32'h0000_0100 one cycle after req at 32'h10:
  - req holds at 32'h10 until ack and the data is dropped.
  - Next req is at 32'h100.
  - First delivered inst_next_pc = 32'h104.
- Redirect in the same cycle as ack and with a non-empty FIFO: inst_valid = 0 that cycle, FIFO count = 0 next cycle, next imem_addr = redirect_pc.
- Two redirects during DISCARD (targets 32'h200 then 32'h300): after the ack, the fetch goes to 32'h300 only.
- rst asserted mid-WAIT: outputs return to reset values immediately. After release, the first req is at RESET_PC and the stale ack is ignored.

Source files
------------

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and constants for the instruction fetch queue.
package ifq_pkg;

  localparam int unsigned INSN_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {IDLE, FETCH, FULL, DISCARD} state_t;

  // One prefetched word and the sequential pc that follows it.
  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [31:0]       next_pc;
  } entry_t;

  // Instruction addresses are word aligned; low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry synchronous FIFO of fetch entries with flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifq_fifo import ifq_pkg::*; #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        wdata,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          empty
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // pointers and occupancy; flush wins over a same-cycle push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // storage; no reset, the head is only looked at while count != 0
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: prefetching instruction-fetch front end feeding IF/ID.
// Keeps exactly one read outstanding on a req/ack instruction memory,
// buffers sequential words in ifq_fifo and honours freeze and redirect.
// Optional macro IFQ_BYPASS_EN: an ack into an empty queue is presented
// to IF/ID in the same cycle instead of one cycle later.
module ifetch_queue import ifq_pkg::*; #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        freeze,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_next_pc
);

  localparam int unsigned   CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, pend_pc_q, pend_pc_d, addr_d;
  logic [31:0]   tgt_pc, pc_inc;
  logic          req_d, ack, bypass, push, pop, fifo_empty, room;
  logic [CW-1:0] fifo_count, cnt_nxt;
  entry_t        fill, head, fifo_head;

  assign ack    = imem_ack & imem_req;   // acks with no request are ignored
  assign tgt_pc = word_align(redirect_pc);
  assign pc_inc = fetch_pc_q + PC_INC;
  assign fill   = '{insn: imem_rdata, next_pc: pc_inc};

`ifdef IFQ_BYPASS_EN
  assign bypass = fifo_empty & ack & ~redirect & (state_q == FETCH);
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that IF/ID takes right away never enters the FIFO.
  assign push = ack & ~redirect & (state_q == FETCH) & ~(bypass & ~freeze);
  assign pop  = ~fifo_empty & ~redirect & ~freeze;

  // Occupancy after this edge; no request is outstanding whenever this
  // is used to decide on issuing the next one.
  assign cnt_nxt = redirect ? '0 : fifo_count + CW'(push) - CW'(pop);
  assign room    = cnt_nxt < DEPTH_C;

  assign head         = bypass ? fill : fifo_head;
  assign inst_valid   = (~fifo_empty | bypass) & ~redirect;
  assign inst         = inst_valid ? head.insn    : '0;
  assign inst_next_pc = inst_valid ? head.next_pc : '0;

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (fill),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // next state, fetch/pending pc and the registered request for next cycle
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    addr_d     = imem_addr;
    unique case (state_q)
      IDLE: begin
        state_d    = FETCH;
        fetch_pc_d = redirect ? tgt_pc : fetch_pc_q;
        addr_d     = fetch_pc_d;
      end
      FETCH: begin
        if (redirect && !ack) begin
          // request must complete at its old address; its data is dead
          state_d   = DISCARD;
          pend_pc_d = tgt_pc;
        end else if (redirect) begin
          fetch_pc_d = tgt_pc;
          addr_d     = tgt_pc;
        end else if (ack) begin
          fetch_pc_d = pc_inc;
          addr_d     = pc_inc;
          if (!room) state_d = FULL;
        end
      end
      FULL: begin
        if (redirect) begin
          state_d    = FETCH;
          fetch_pc_d = tgt_pc;
          addr_d     = tgt_pc;
        end else if (room) begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (redirect) pend_pc_d = tgt_pc;
        if (ack) begin
          state_d    = FETCH;
          fetch_pc_d = pend_pc_d;
          addr_d     = pend_pc_d;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == FETCH) || (state_d == DISCARD);
  end

  // state, pcs and the memory request are all registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      imem_addr  <= RESET_PC;
      imem_req   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      imem_addr  <= addr_d;
      imem_req   <= req_d;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: vector table, hand-written corner sequences and a
// randomized run against a program-order model of the fetch stream.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        freeze = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_next_pc;

  int n_chk  = 0;
  int n_pass = 0;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .freeze       (freeze),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_next_pc (inst_next_pc)
  );

  always #5 clk = ~clk;

  // memory contents as a function of the word address
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  // apply one cycle's inputs (shortly after the rising edge) and settle
  task automatic drive(input logic r, input logic rd, input logic [31:0] rp,
                       input logic fz, input logic ak);
    rst         = r;
    redirect    = rd;
    redirect_pc = rp;
    freeze      = fz;
    imem_ack    = ak;
    imem_rdata  = ak ? mem_f(imem_addr) : 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  typedef struct {
    logic        r, rd;
    logic [31:0] rpc;
    logic        fz, ak;
    logic        req, ca;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] npc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                              input logic fz, input logic ak, input logic req,
                              input logic ca, input logic [31:0] addr,
                              input logic vld, input logic [31:0] npc);
    vec_t v;
    v.r = r; v.rd = rd; v.rpc = rpc; v.fz = fz; v.ak = ak;
    v.req = req; v.ca = ca; v.addr = addr; v.vld = vld; v.npc = npc;
    return v;
  endfunction

  vec_t tbl [25];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        busy;
    logic [1:0]  lat;
    logic [31:0] cap_addr, exp_pc;
    int          delivered;

    // zero-wait memory, then freeze to FULL, release, redirect with ack
    tbl[0]  = mk(0,0,0,0,1, 0,1,32'h00, 0,32'h00);
    tbl[1]  = mk(1,0,0,0,1, 0,1,32'h00, 0,32'h00);
    tbl[2]  = mk(1,0,0,0,1, 1,1,32'h00, 0,32'h00);
    tbl[3]  = mk(1,0,0,0,1, 1,1,32'h04, 1,32'h04);
    tbl[4]  = mk(1,0,0,0,1, 1,1,32'h08, 1,32'h08);
    tbl[5]  = mk(1,0,0,0,1, 1,1,32'h0C, 1,32'h0C);
    tbl[6]  = mk(0,0,0,1,1, 0,1,32'h00, 0,32'h00);
    tbl[7]  = mk(1,0,0,1,1, 0,1,32'h00, 0,32'h00);
    tbl[8]  = mk(1,0,0,1,1, 1,1,32'h00, 0,32'h00);
    tbl[9]  = mk(1,0,0,1,1, 1,1,32'h04, 1,32'h04);
    tbl[10] = mk(1,0,0,1,1, 1,1,32'h08, 1,32'h04);
    tbl[11] = mk(1,0,0,1,1, 1,1,32'h0C, 1,32'h04);
    for (int i = 12; i < 17; i++) tbl[i] = mk(1,0,0,1,1, 0,0,32'h0, 1,32'h04);
    tbl[17] = mk(1,0,0,0,1, 0,0,32'h00, 1,32'h04);
    tbl[18] = mk(1,0,0,0,1, 1,1,32'h10, 1,32'h08);
    tbl[19] = mk(1,0,0,0,1, 1,1,32'h14, 1,32'h0C);
    tbl[20] = mk(1,0,0,0,1, 1,1,32'h18, 1,32'h10);
    tbl[21] = mk(1,0,0,0,1, 1,1,32'h1C, 1,32'h14);
    tbl[22] = mk(1,1,32'h43,0,1, 1,1,32'h20, 0,32'h00);
    tbl[23] = mk(1,0,0,0,1, 1,1,32'h40, 0,32'h00);
    tbl[24] = mk(1,0,0,0,1, 1,1,32'h44, 1,32'h44);

    #1;
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].r, tbl[i].rd, tbl[i].rpc, tbl[i].fz, tbl[i].ak);
      chk1($sformatf("v%0d_req", i), imem_req, tbl[i].req);
      if (tbl[i].ca) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
      chk1($sformatf("v%0d_valid", i), inst_valid, tbl[i].vld);
      chk($sformatf("v%0d_npc", i), inst_next_pc, tbl[i].npc);
      chk($sformatf("v%0d_inst", i), inst, tbl[i].vld ? mem_f(tbl[i].npc - 32'd4) : 32'h0);
      tick();
    end

    // latency-3 memory, redirect while the request at 0x10 is pending
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1,0,0,0,1); tick(); end
    drive(1,0,0,0,0); chk("s1_req_at_10", imem_addr, 32'h10); tick();
    drive(1,1,32'h100,0,0); chk1("s1_squash", inst_valid, 1'b0); tick();
    drive(1,0,0,0,0); chk1("s1_req_held", imem_req, 1'b1);
    chk("s1_addr_held", imem_addr, 32'h10); tick();
    drive(1,0,0,0,1); chk("s1_addr_at_ack", imem_addr, 32'h10); tick();
    drive(1,0,0,0,1); chk("s1_new_addr", imem_addr, 32'h100);
    chk1("s1_dropped", inst_valid, 1'b0); tick();
    drive(1,0,0,0,0); chk1("s1_valid", inst_valid, 1'b1);
    chk("s1_npc", inst_next_pc, 32'h104);
    chk("s1_inst", inst, mem_f(32'h100)); tick();

    // redirects stacked while discarding: only the last target is fetched
    do_reset();
    drive(1,0,0,0,0); tick();
    drive(1,1,32'h180,0,0); chk("s2_addr0", imem_addr, 32'h0); tick();
    drive(1,1,32'h200,0,0); chk("s2_hold_a", imem_addr, 32'h0); tick();
    drive(1,1,32'h300,0,0); chk1("s2_hold_req", imem_req, 1'b1); tick();
    drive(1,0,0,0,1); chk("s2_hold_b", imem_addr, 32'h0); tick();
    drive(1,0,0,0,1); chk("s2_target", imem_addr, 32'h300); tick();
    drive(1,0,0,0,0); chk1("s2_valid", inst_valid, 1'b1);
    chk("s2_npc", inst_next_pc, 32'h304); tick();

    // reset while a request waits, stale ack after release
    do_reset();
    drive(1,0,0,0,0); tick();
    drive(1,0,0,0,1); tick();
    drive(1,0,0,0,1); tick();
    drive(1,0,0,0,0); chk("s3_wait_addr", imem_addr, 32'h8);
    drive(0,0,0,0,0);
    chk1("s3_rst_req", imem_req, 1'b0);
    chk("s3_rst_addr", imem_addr, 32'h0);
    chk1("s3_rst_valid", inst_valid, 1'b0);
    chk("s3_rst_inst", inst, 32'h0);
    chk("s3_rst_npc", inst_next_pc, 32'h0);
    tick();
    drive(1,0,0,0,1); chk1("s3_stale_req", imem_req, 1'b0); tick();
    drive(1,0,0,0,0); chk1("s3_req", imem_req, 1'b1);
    chk("s3_addr", imem_addr, 32'h0); chk1("s3_novalid", inst_valid, 1'b0); tick();
    drive(1,0,0,0,1); tick();
    drive(1,0,0,0,0); chk("s3_npc", inst_next_pc, 32'h4);
    chk("s3_inst", inst, mem_f(32'h0)); tick();

    // random latency, freeze, redirects and spurious acks
    busy = 1'b0; lat = '0; cap_addr = '0; exp_pc = 32'h0; delivered = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic ak, rd, fz;
      logic [31:0] rp;
      if (busy) begin
        chk1("rnd_req_hold", imem_req, 1'b1);
        chk("rnd_addr_hold", imem_addr, cap_addr);
      end else if (imem_req) begin
        busy = 1'b1;
        lat = 2'($urandom_range(0, 3));
        cap_addr = imem_addr;
        chk("rnd_addr_align", imem_addr & 32'h3, 32'h0);
      end
      if (busy) ak = (lat == 2'd0);
      else      ak = ($urandom_range(0, 3) == 0);
      if (busy && lat != 2'd0) lat = lat - 2'd1;
      rd = ($urandom_range(0, 19) == 0);
      rp = $urandom;
      fz = ($urandom_range(0, 3) == 0);
      drive(1'b1, rd, rp, fz, ak);
      if (rd) begin
        chk1("rnd_squash", inst_valid, 1'b0);
      end else if (inst_valid && !fz) begin
        chk("rnd_npc", inst_next_pc, exp_pc + 32'd4);
        chk("rnd_inst", inst, mem_f(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (rd) exp_pc = rp & 32'hFFFF_FFFC;
      if (busy && ak) busy = 1'b0;
      tick();
    end
    chk1("rnd_progress", delivered > 300, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
